// File: rtl/button_conditioner.sv
// Button conditioner: per-bit 2-flop synchroniser, polarity normalisation,
// counter-based debouncer with registered press/release pulses, and a
// three-state arbiter that latches which touch input (player 1 / player 2)
// is pressed first after an arm pulse.
module button_conditioner #(
  parameter int unsigned NUM_BUTTONS     = 5,
  parameter bit          INVERTED_INPUT  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                   clock,
  input  logic                   globalReset,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  input  logic                   arm,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release,
  output logic [1:0]             first_touch,
  output logic                   first_valid
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  // The counter value seen on the edge that completes a stable run. Reaching
  // DEBOUNCE_CYCLES and clearing happen on the same edge, so the register never
  // actually holds DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // Raw level of a released button; the synchroniser resets to it so that a
  // reset never looks like an edge on the physical input.
  localparam logic [NUM_BUTTONS-1:0] RawIdle = {NUM_BUTTONS{INVERTED_INPUT}};

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StLatched = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] sync_active;

  // Two-flop synchroniser for the asynchronous raw inputs.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      sync1_q <= RawIdle;
      sync2_q <= RawIdle;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity: 1 always means pressed from here on.
  assign sync_active = sync2_q ^ RawIdle;

  // ---------------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]           level_q, level_d;
  logic [NUM_BUTTONS-1:0]           press_q, press_d;
  logic [NUM_BUTTONS-1:0]           release_q, release_d;
  logic [NUM_BUTTONS-1:0]           toggle;

  // Per-bit stability counters; a level flips only after an unbroken run of
  // DEBOUNCE_CYCLES cycles disagreeing with the current debounced level.
  always_comb begin
    cnt_d  = cnt_q;
    toggle = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (sync_active[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          cnt_d[i]  = '0;
          toggle[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Next debounced level and the edge pulses that accompany a flip.
  always_comb begin
    level_d   = level_q ^ toggle;
    press_d   = toggle & ~level_q;
    release_d = toggle & level_q;
  end

  // Debouncer state and registered pulse outputs.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign button_level   = level_q;
  assign button_press   = press_q;
  assign button_release = release_q;

  // ---------------------------------------------------------------------------
  // First-touch arbiter
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] first_touch_q, first_touch_d;
  logic       first_valid_q, first_valid_d;
  logic [1:0] touch_press;

  // Only the two touch inputs take part in arbitration.
  assign touch_press = press_q[1:0];

  // Arbiter next state; arm has priority over any coincident touch press.
  always_comb begin
    state_d       = state_q;
    first_touch_d = first_touch_q;
    first_valid_d = first_valid_q;
    if (arm) begin
      state_d       = StArmed;
      first_touch_d = 2'b00;
      first_valid_d = 1'b0;
    end else begin
      case (state_q)
        StArmed: begin
          if (|touch_press) begin
            state_d       = StLatched;
            first_touch_d = touch_press;
            first_valid_d = 1'b1;
          end
        end
        StIdle, StLatched: begin
          state_d = state_q;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Arbiter state and registered decision outputs.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      state_q       <= StIdle;
      first_touch_q <= 2'b00;
      first_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_touch_q <= first_touch_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign first_touch = first_touch_q;
  assign first_valid = first_valid_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 5: number of raw button inputs. Bit 0 is the player-1 touch, bit 1 the player-2 touch, bits 2..4 are up/down/select.
REQ-002 SHALL have parameter INVERTED_INPUT, default 1: 1 means raw inputs are active-low, 0 means active-high.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before a level change is accepted; legal range >= 2.
REQ-004 SHALL have port clock, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port globalReset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port button_raw, input, NUM_BUTTONS bits: asynchronous physical button/touch inputs.
REQ-007 SHALL have port arm, input, 1 bit: single-cycle pulse that opens a reaction window (the "BANG" moment).
REQ-008 SHALL have port button_level, output, NUM_BUTTONS bits: debounced, active-high pressed state.
REQ-009 SHALL have port button_press, output, NUM_BUTTONS bits: one-cycle pulse per debounced press.
REQ-010 SHALL have port button_release, output, NUM_BUTTONS bits: one-cycle pulse per debounced release.
REQ-011 SHALL have port first_touch, output, 2 bits: latched touch winner (01 = player 1, 10 = player 2, 11 = tie).
REQ-012 SHALL have port first_valid, output, 1 bit: high while first_touch holds a decision.

Function
REQ-013 Each raw bit SHALL pass through a 2-flop synchroniser, then be XORed with INVERTED_INPUT so the result is active-high.
REQ-014 Each bit SHALL have an independent counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
- Counter increments on every cycle where the synchronised value differs from button_level.
- Counter clears to 0 on any cycle where they match.
REQ-015 When the counter reaches DEBOUNCE_CYCLES, on that edge button_level SHALL toggle and the counter SHALL clear.
- Latency from a clean raw change to the button_level change is DEBOUNCE_CYCLES+2 edges.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronisation) SHALL produce no change on button_level, button_press or button_release.
REQ-017 button_press[i] SHALL be high for exactly the first cycle in which button_level[i] is 1. button_release[i] SHALL be high for exactly the first cycle in which button_level[i] is 0 after having been 1. Both SHALL be registered, not combinational.
REQ-018 Holding a button SHALL yield one button_press only; there is no auto-repeat.
REQ-019 The arbiter FSM SHALL have the states IDLE, ARMED and LATCHED.
REQ-020 The FSM transitions SHALL be:
- IDLE --arm--> ARMED.
- ARMED --button_press[0] or button_press[1]--> LATCHED.
- LATCHED --arm--> ARMED.
- Every other combination holds the current state.
REQ-021 On entry to ARMED, first_touch SHALL clear to 00 and first_valid SHALL clear to 0.
REQ-022 On the ARMED->LATCHED edge, first_touch SHALL load {button_press[1], button_press[0]} and first_valid SHALL go to 1.
- A same-cycle press of both touches SHALL latch 11 (tie).
REQ-023 Presses in IDLE or LATCHED SHALL be ignored by the arbiter, as SHALL presses that occur before arm.
REQ-024 If arm and a touch press coincide, arm SHALL win: the state becomes or stays ARMED, outputs clear, and the press is discarded.
REQ-025 arm in ARMED SHALL keep ARMED and re-clear the outputs.
REQ-026 Bits 2..NUM_BUTTONS-1 SHALL NOT affect the arbiter.

Reset
REQ-027 While globalReset is high at a clock edge, the block SHALL:
- clear the synchroniser flops to the de-asserted raw level (1 if INVERTED_INPUT, else 0);
- clear all counters;
- clear button_level, button_press, button_release, first_touch and first_valid to 0;
- set the FSM to IDLE.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count. After release, a held button SHALL require the full DEBOUNCE_CYCLES+2 edges before button_level rises and button_press pulses.
REQ-029 Reset SHALL never cause a press or release pulse, either during reset or on the first cycle after release.

Verification (DEBOUNCE_CYCLES=4, INVERTED_INPUT=1)
REQ-030 Scenario: button_raw[2] goes 1->0 and holds. Required: button_level[2] rises exactly 6 edges later, button_press[2] is high that one cycle, all other bits stay 0.
REQ-031 Scenario: button_raw[0] goes low for 3 cycles, then high. Required: button_level, button_press and first_touch stay 0 throughout.
REQ-032 Scenario: arm pulse, then player-2 touch held. Required: first_touch=10, first_valid=1; a later player-1 touch leaves them unchanged.
REQ-033 Scenario: arm pulse, then both touches fall on the same edge. Required: first_touch=11, first_valid=1.
REQ-034 Scenario: player-1 touch pressed before arm and held, then arm pulses. Required: state ARMED, first_valid=0, no latch until a new press (release then re-press) occurs.
REQ-035 Scenario: globalReset asserted 2 cycles into a debounce, then released with the button still held. Required: no pulse during or just after reset, and button_press fires 6 edges after release.
